// File: rtl/ex_div_iter.sv
// Iterative radix-2 restoring divider for EX1 lane 0: one quotient bit per cycle,
// optional early-out on short dividends, valid/ready on both sides, flush-killable.
module ex_div_iter #(
  parameter int WIDTH     = 32,
  parameter int EARLY_OUT = 1
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH:0]   rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] raw_dvd_reg;
  logic [CW-1:0]    cnt_reg;
  logic [CW-1:0]    n_reg;
  logic             q_neg_reg;
  logic             r_neg_reg;
  logic             dz_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             ready_en_reg;

  logic             accept;
  logic [WIDTH-1:0] abs_dvd;
  logic [WIDTH-1:0] abs_dvs;
  logic [CW-1:0]    dvd_len;
  logic [CW-1:0]    n_accept;
  logic [CW-1:0]    shamt;
  logic [WIDTH-1:0] dvd_pre;
  logic             dz_accept;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             q_bit;
  logic [CW-1:0]    cnt_next;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign in_ready  = (state_reg == S_IDLE) && ready_en_reg;
  assign res_valid = (state_reg == S_DONE);
  assign busy      = (state_reg == S_CALC) || (state_reg == S_FIX);
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;

  assign accept = in_ready && in_valid && !flush;

  // Operand conditioning at accept time
  assign abs_dvd   = (sign && dividend[WIDTH-1]) ? ('0 - dividend) : dividend;
  assign abs_dvs   = (sign && divisor[WIDTH-1])  ? ('0 - divisor)  : divisor;
  assign dz_accept = (divisor == '0);

  always_comb begin
    dvd_len = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (abs_dvd[i]) begin
        dvd_len = CW'(i + 1);
      end
    end
  end

  always_comb begin
    n_accept = '0;
    if (!dz_accept) begin
      n_accept = (EARLY_OUT != 0) ? dvd_len : CW'(WIDTH);
    end
  end

  // Leading zeros of the dividend are skipped by pre-aligning its MSB.
  assign shamt   = CW'(WIDTH) - n_accept;
  assign dvd_pre = abs_dvd << shamt;

  // One restoring step; WIDTH+1 bits so the shifted remainder never overflows.
  assign rem_shift = {rem_reg[WIDTH-1:0], dvd_reg[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, dvs_reg};
  assign q_bit     = ~rem_diff[WIDTH];
  assign cnt_next  = cnt_reg + CW'(1);

  assign q_fix = q_neg_reg ? ('0 - quo_reg) : quo_reg;
  assign r_fix = r_neg_reg ? ('0 - rem_reg[WIDTH-1:0]) : rem_reg[WIDTH-1:0];

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            state_next = (n_accept != '0) ? S_CALC : S_FIX;
          end
        end
        S_CALC: begin
          if (cnt_next == n_reg) begin
            state_next = S_FIX;
          end
        end
        S_FIX: begin
          state_next = S_DONE;
        end
        S_DONE: begin
          if (res_ready) begin
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg    <= S_IDLE;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ready_en_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      dvd_reg       <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      dvs_reg       <= '0;
      raw_dvd_reg   <= '0;
      cnt_reg       <= '0;
      n_reg         <= '0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      dz_reg        <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      if (accept) begin
        dvd_reg     <= dvd_pre;
        rem_reg     <= '0;
        quo_reg     <= '0;
        dvs_reg     <= abs_dvs;
        raw_dvd_reg <= dividend;
        cnt_reg     <= '0;
        n_reg       <= n_accept;
        q_neg_reg   <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        r_neg_reg   <= sign & dividend[WIDTH-1];
        dz_reg      <= dz_accept;
      end else if (state_reg == S_CALC && !flush) begin
        dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b0};
        rem_reg <= q_bit ? rem_diff : rem_shift;
        quo_reg <= {quo_reg[WIDTH-2:0], q_bit};
        cnt_reg <= cnt_next;
      end

      if (state_reg == S_FIX && !flush) begin
        if (dz_reg) begin
          quotient_reg  <= '1;
          remainder_reg <= raw_dvd_reg;
        end else begin
          quotient_reg  <= q_fix;
          remainder_reg <= r_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_div_iter.sv
// Bench for ex_div_iter: instance 0 without early-out, instance 1 with early-out,
// scoreboard of expected quotient/remainder/latency filled at accept time.
module tb_ex_div_iter;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        flush;
  logic        sign;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [1:0]  res_valid;
  logic [1:0]  res_ready;
  logic [1:0]  busy;
  logic [31:0] quotient [2];
  logic [31:0] remainder [2];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      ex_div_iter #(.WIDTH(32), .EARLY_OUT(gi)) dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .flush     (flush),
        .in_valid  (in_valid[gi]),
        .in_ready  (in_ready[gi]),
        .sign      (sign),
        .dividend  (dividend),
        .divisor   (divisor),
        .res_valid (res_valid[gi]),
        .res_ready (res_ready[gi]),
        .quotient  (quotient[gi]),
        .remainder (remainder[gi]),
        .busy      (busy[gi])
      );
    end
  endgenerate

  function automatic exp_t model(input int sel, input logic sgn, input logic [31:0] a,
                                 input logic [31:0] b, input string name);
    exp_t e;
    logic [31:0] a_abs;
    int len;
    e.name = name;
    a_abs = (sgn && a[31]) ? (32'd0 - a) : a;
    len = 0;
    for (int i = 0; i < 32; i++) if (a_abs[i]) len = i + 1;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
      e.lat = 2;
    end else begin
      if (!sgn) begin
        e.q = a / b;
        e.r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = 32'h8000_0000;
        e.r = 32'd0;
      end else begin
        e.q = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end
      e.lat = (sel == 0) ? 34 : 2 + len;
    end
    return e;
  endfunction

  task automatic accept_op(input int sel, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input string name, output int waited);
    waited = 0;
    @(negedge clk);
    sign = sgn;
    dividend = a;
    divisor = b;
    in_valid[sel] = 1'b1;
    while (!in_ready[sel] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_tests++;
    if (in_ready[sel] !== 1'b1) begin
      $display("FAIL %s accept_timeout in_ready=%b required 1", name, in_ready[sel]);
      n_fail++;
    end
    @(posedge clk);
    #1;
    in_valid[sel] = 1'b0;
    sb.push_back(model(sel, sgn, a, b, name));
    // scramble the operands: only the values sampled at accept may matter
    dividend = $urandom;
    divisor = $urandom;
    sign = ~sgn;
  endtask

  task automatic wait_result(input int sel);
    exp_t e;
    int cyc;
    cyc = 1;
    while (!res_valid[sel] && cyc < 100) begin
      n_tests++;
      if (busy[sel] !== 1'b1) begin
        $display("FAIL busy_while_pending cycle=%0d got=%b required 1", cyc, busy[sel]);
        n_fail++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    e = sb.pop_front();
    n_tests++;
    if (res_valid[sel] !== 1'b1) begin
      $display("FAIL %s res_valid_timeout got=%b required 1", e.name, res_valid[sel]);
      n_fail++;
    end
    n_tests++;
    if (cyc !== e.lat) begin
      $display("FAIL %s latency got=%0d required %0d", e.name, cyc, e.lat);
      n_fail++;
    end
    n_tests++;
    if (quotient[sel] !== e.q) begin
      $display("FAIL %s quotient got=%h required %h", e.name, quotient[sel], e.q);
      n_fail++;
    end
    n_tests++;
    if (remainder[sel] !== e.r) begin
      $display("FAIL %s remainder got=%h required %h", e.name, remainder[sel], e.r);
      n_fail++;
    end
    n_tests++;
    if (busy[sel] !== 1'b0) begin
      $display("FAIL %s busy_in_done got=%b required 0", e.name, busy[sel]);
      n_fail++;
    end
    $display("[TB] dut%0d %s q=%h r=%h lat=%0d", sel, e.name, quotient[sel], remainder[sel], cyc);
  endtask

  task automatic release_result(input int sel);
    @(negedge clk);
    res_ready[sel] = 1'b1;
    @(posedge clk);
    #1;
    res_ready[sel] = 1'b0;
    n_tests++;
    if (in_ready[sel] !== 1'b1 || res_valid[sel] !== 1'b0) begin
      $display("FAIL release in_ready=%b res_valid=%b required 1/0", in_ready[sel], res_valid[sel]);
      n_fail++;
    end
  endtask

  task automatic do_op(input int sel, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input string name);
    int w;
    accept_op(sel, sgn, a, b, name, w);
    wait_result(sel);
    release_result(sel);
  endtask

  task automatic check_idle_outputs(input string name, input logic [1:0] ready_req);
    for (int s = 0; s < 2; s++) begin
      n_tests++;
      if (res_valid[s] !== 1'b0 || busy[s] !== 1'b0 || in_ready[s] !== ready_req[s] ||
          quotient[s] !== 32'd0 || remainder[s] !== 32'd0) begin
        $display("FAIL %s dut%0d rv=%b busy=%b rdy=%b q=%h r=%h required 0/0/%b/0/0",
                 name, s, res_valid[s], busy[s], in_ready[s], quotient[s], remainder[s],
                 ready_req[s]);
        n_fail++;
      end
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    flush = 1'b0;
    sign = 1'b0;
    dividend = '0;
    divisor = '0;
    in_valid = '0;
    res_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_hold", 2'b00);
    @(negedge clk);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (in_ready !== 2'b11 || res_valid !== 2'b00 || busy !== 2'b00) begin
      $display("FAIL reset_release in_ready=%b res_valid=%b busy=%b required 11/00/00",
               in_ready, res_valid, busy);
      n_fail++;
    end
  endtask

  task automatic test_unsigned();
    do_op(0, 1'b0, 32'd100, 32'd7, "u_100_7");
    do_op(0, 1'b0, 32'hFFFF_FFFF, 32'd3, "u_max_3");
    do_op(0, 1'b0, 32'd5, 32'd9, "u_small_big");
    do_op(1, 1'b0, 32'd100, 32'd7, "eo_u_100_7");
  endtask

  task automatic test_signed();
    do_op(0, 1'b1, -32'sd7, 32'd2, "s_m7_2");
    do_op(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "s_ovf");
    do_op(1, 1'b1, -32'sd7, 32'd2, "eo_s_m7_2");
    do_op(1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "eo_s_ovf");
    do_op(1, 1'b1, 32'd100, -32'sd7, "eo_s_100_m7");
    do_op(0, 1'b1, -32'sd100, -32'sd7, "s_m100_m7");
  endtask

  task automatic test_early_out();
    do_op(1, 1'b0, 32'd5, 32'd3, "eo_5_3");
    do_op(1, 1'b0, 32'd0, 32'd9, "eo_zero_dvd");
    do_op(1, 1'b0, 32'hFFFF_FFFF, 32'd1, "eo_full_len");
    do_op(1, 1'b1, 32'hFFFF_FFFF, 32'd1, "eo_s_m1_1");
    do_op(0, 1'b0, 32'd0, 32'd9, "zero_dvd_noeo");
  endtask

  task automatic test_div_zero();
    do_op(0, 1'b0, 32'h1234, 32'd0, "dz_1234");
    do_op(1, 1'b0, 32'h1234, 32'd0, "eo_dz_1234");
    do_op(1, 1'b1, -32'sd5, 32'd0, "eo_dz_s_m5");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 16; i++) begin
      a = $urandom >> $urandom_range(0, 31);
      b = $urandom >> $urandom_range(16, 31);
      do_op(i % 2, 1'($urandom_range(0, 1)), a, b, "rand");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q_hold;
    logic [31:0] r_hold;
    int w;
    accept_op(1, 1'b0, 32'd1000, 32'd10, "b2b_first", w);
    wait_result(1);
    q_hold = quotient[1];
    r_hold = remainder[1];
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (res_valid[1] !== 1'b1 || in_ready[1] !== 1'b0 ||
          quotient[1] !== q_hold || remainder[1] !== r_hold) begin
        $display("FAIL backpressure cycle=%0d rv=%b rdy=%b q=%h r=%h required 1/0/%h/%h",
                 i, res_valid[1], in_ready[1], quotient[1], remainder[1], q_hold, r_hold);
        n_fail++;
      end
    end
    release_result(1);
    accept_op(1, 1'b1, -32'sd100, 32'd7, "b2b_second", w);
    n_tests++;
    if (w !== 0) begin
      $display("FAIL b2b_accept_delay got=%0d required 0", w);
      n_fail++;
    end
    wait_result(1);
    release_result(1);
  endtask

  task automatic test_flush();
    exp_t dropped;
    int w;
    int seen;
    accept_op(0, 1'b0, 32'd100, 32'd7, "flush_calc", w);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    dropped = sb.pop_back();
    n_tests++;
    if (busy[0] !== 1'b0 || res_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      $display("FAIL flush_to_idle busy=%b rv=%b rdy=%b required 0/0/1",
               busy[0], res_valid[0], in_ready[0]);
      n_fail++;
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (res_valid[0] === 1'b1) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      $display("FAIL flush_no_result %s res_valid_cycles=%0d required 0", dropped.name, seen);
      n_fail++;
    end
    @(negedge clk);
    dividend = 32'd77;
    divisor = 32'd5;
    in_valid = 2'b11;
    flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 2'b00;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 2'b00 || in_ready !== 2'b11 || res_valid !== 2'b00) begin
      $display("FAIL flush_with_valid busy=%b rdy=%b rv=%b required 00/11/00",
               busy, in_ready, res_valid);
      n_fail++;
    end
    do_op(0, 1'b0, 32'd77, 32'd5, "after_flush");
  endtask

  task automatic test_reset_mid();
    exp_t dropped;
    int w;
    accept_op(0, 1'b0, 32'd100, 32'd7, "reset_mid", w);
    repeat (5) @(posedge clk);
    @(negedge clk);
    aresetn = 1'b0;
    #1;
    dropped = sb.pop_back();
    check_idle_outputs("reset_mid_calc", 2'b00);
    @(negedge clk);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (in_ready !== 2'b11 || busy !== 2'b00 || res_valid !== 2'b00) begin
      $display("FAIL %s_release rdy=%b busy=%b rv=%b required 11/00/00",
               dropped.name, in_ready, busy, res_valid);
      n_fail++;
    end
    do_op(0, 1'b0, 32'd100, 32'd7, "after_reset");
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_early_out();
    test_div_zero();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_div_iter.md
Name: ex_div_iter

Overview:
- Parametrised iterative radix-2 integer divider for the EX1 stage, lane 0. It is the successor to the fixed 32-bit divider.
- Generic in operand width, with an optional early-out on short dividends.
- Uses an explicit valid/ready handshake on both the input and output sides.
- Supports a pipeline flush that kills any in-flight operation.
- EX1 drives operands from the forwarded rj/rk data, and WB consumes quotient and remainder.

Parameters:
- WIDTH, 32: operand and result width in bits; must be at least 4.
- EARLY_OUT, 1: when 1, the iteration count equals the bit length of |dividend|; when 0, it is always WIDTH.

Ports:
- clk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush (branch mispredict, ertn, exception); kills the current operation.
- in_valid  in  1  operands valid.
- in_ready  out  1  divider can accept; high only in IDLE.
- sign  in  1  1 = signed (div.w/mod.w), 0 = unsigned (div.wu/mod.wu).
- dividend  in  WIDTH  rj operand.
- divisor  in  WIDTH  rk operand.
- res_valid  out  1  result valid; held until accepted.
- res_ready  in  1  consumer accepts the result.
- quotient  out  WIDTH  quotient.
- remainder  out  WIDTH  remainder.
- busy  out  1  high in CALC or FIX; EX1 ORs it into stall_divider.

Behaviour:
- Reset, asynchronous on aresetn low:
  - state = IDLE; res_valid = 0; busy = 0; quotient = 0; remainder = 0; in_ready = 1 after release.
  - Reset mid-operation discards all state.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - Accept on in_valid && in_ready && !flush; call this cycle T.
  - At accept, latch:
    - |dividend| and |divisor| (absolute value taken only when sign=1 and the MSB is set);
    - q_neg = sign & (dvd_msb ^ dvs_msb);
    - r_neg = sign & dvd_msb;
    - dz = (divisor == 0);
    - iteration count N:
      - N = 0 if dz;
      - otherwise N = WIDTH if EARLY_OUT = 0;
      - otherwise N = bit length of |dividend| (0 for a zero dividend, WIDTH when the MSB of |dividend| is set).
  - Next state is CALC if N > 0, else FIX.
- CALC, one quotient bit per cycle, restoring algorithm:
  - Shift partial remainder and dividend left by one.
  - Compare against |divisor|; subtract if greater or equal, setting the quotient bit.
  - Arithmetic is WIDTH+1 bits wide, so no overflow is possible.
  - When the counter reaches N, go to FIX.
  - With early-out, the dividend register is pre-shifted left by WIDTH-N at accept, so the leading zeros are skipped.
- FIX:
  - quotient = q_neg ? -q : q; remainder = r_neg ? -r : r (two's complement, truncated to WIDTH).
  - If dz: quotient = all ones and remainder = dividend (raw, unsigned view). The ISA leaves this undefined; the behaviour is fixed here for determinism.
  - Signed overflow, most-negative / -1: quotient = most-negative and remainder = 0. This falls out of the WIDTH-bit wrap naturally.
  - Next state: DONE.
- DONE:
  - res_valid = 1, and quotient/remainder are stable.
  - Go to IDLE in the cycle after res_valid && res_ready.
  - in_ready stays low in DONE, so the next accept is no earlier than the cycle after the handshake.
- Latency:
  - res_valid is first high at cycle T+2+N.
  - Worst case is WIDTH+2 cycles; the dz case is 2 cycles.
- flush:
  - Highest priority in every state; next state is IDLE and res_valid goes low the next cycle.
  - A flush coinciding with in_valid does not accept.
  - A flush coinciding with res_valid && res_ready: the handshake is void, and the consumer ignores it because it sees the same flush.
- busy = (state == CALC) || (state == FIX).
- Operands are sampled only at accept; input changes afterwards have no effect.

Test Plan:
- WIDTH=32, EARLY_OUT=0, unsigned 100/7 accepted at T → quotient 14, remainder 2, res_valid at T+34, busy high T+1..T+33.
- Signed -7/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- EARLY_OUT=1, unsigned 5/3 → N=3, quotient 1, remainder 2, res_valid at T+5. Dividend 0 → quotient 0, remainder 0 at T+2.
- Divisor 0, dividend 0x1234 → quotient 0xFFFFFFFF, remainder 0x1234, res_valid at T+2.
- Back-pressure and back-to-back:
  - Hold res_ready=0 for 5 cycles in DONE → outputs stable and in_ready=0.
  - Raise res_ready → IDLE next cycle; a second op is accepted then and completes correctly.
- flush in CALC cycle T+10 → IDLE at T+11, no res_valid. Also check flush together with in_valid (no accept), and aresetn low mid-CALC (all outputs 0 immediately).
